// File: rtl/gobang_pkg.sv
// Shared constants, encodings and index helper for the 15x15 five-in-a-row board.
// Used by the move controller and its plane registers.
package gobang_pkg;

  localparam int BOARD_N = 15;
  localparam int CELLS   = BOARD_N * BOARD_N;
  localparam int IDX_W   = 8;

  typedef enum logic {
    BLACK = 1'b0,
    WHITE = 1'b1
  } player_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_OVER  = 2'd2
  } state_e;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
    return IDX_W'(row) * IDX_W'(BOARD_N) + IDX_W'(col);
  endfunction

endpackage

// File: rtl/board_plane.sv
// One occupancy plane of the board: a CELLS-wide register whose bits are only ever set,
// cleared as a whole by reset or by a new game.
module board_plane
  import gobang_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  output logic [CELLS-1:0] plane
);

  logic [CELLS-1:0] plane_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plane_q <= '0;
    end else if (clr) begin
      plane_q <= '0;
    end else if (we) begin
      plane_q[idx] <= 1'b1;
    end
  end

  assign plane = plane_q;

endmodule

// File: rtl/board_move_ctrl.sv
// Move controller: validates requests, places stones, drives the four line checkers
// for one cycle and then alternates turns or ends the game.
module board_move_ctrl
  import gobang_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             new_game,
  input  logic             move_valid,
  input  logic [3:0]       move_row,
  input  logic [3:0]       move_col,
  output logic             move_ready,
  output logic             move_reject,
  output logic             move_done,
  output logic [3:0]       chk_row,
  output logic [3:0]       chk_col,
  output logic [CELLS-1:0] chk_ch,
  input  logic             win_h,
  input  logic             win_v,
  input  logic             win_d1,
  input  logic             win_d2,
  output logic [CELLS-1:0] black_ch,
  output logic [CELLS-1:0] white_ch,
  output logic             turn,
  output logic [7:0]       move_count,
  output logic             game_over,
  output logic             winner,
  output logic             draw
);

  state_e     state_q;
  player_e    turn_q;
  logic [7:0] count_q;
  logic [3:0] chk_row_q, chk_col_q;
  logic       reject_q, done_q, over_q, winner_q, draw_q;

  logic [CELLS-1:0] occ;
  logic [IDX_W-1:0] idx, idx_safe;
  logic             in_range, legal, accept, win_any;
  logic [7:0]       count_d;

  assign occ      = black_ch | white_ch;
  assign in_range = (move_row < 4'(BOARD_N)) && (move_col < 4'(BOARD_N));
  assign idx      = cell_idx(move_row, move_col);
  // Out-of-range requests look up cell 0 instead, and are rejected by in_range anyway.
  assign idx_safe = in_range ? idx : '0;
  assign legal    = in_range && !occ[idx_safe];
  assign accept   = (state_q == S_IDLE) && move_valid && legal && !new_game;
  assign win_any  = win_h | win_v | win_d1 | win_d2;
  assign count_d  = count_q + 8'd1;

  board_plane u_black (
    .clk   (clk),
    .rst   (rst),
    .clr   (new_game),
    .we    (accept && (turn_q == BLACK)),
    .idx   (idx_safe),
    .plane (black_ch)
  );

  board_plane u_white (
    .clk   (clk),
    .rst   (rst),
    .clr   (new_game),
    .we    (accept && (turn_q == WHITE)),
    .idx   (idx_safe),
    .plane (white_ch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      turn_q    <= BLACK;
      count_q   <= '0;
      chk_row_q <= '0;
      chk_col_q <= '0;
      reject_q  <= 1'b0;
      done_q    <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= 1'b0;
      draw_q    <= 1'b0;
    end else if (new_game) begin
      state_q   <= S_IDLE;
      turn_q    <= BLACK;
      count_q   <= '0;
      chk_row_q <= '0;
      chk_col_q <= '0;
      reject_q  <= 1'b0;
      done_q    <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= 1'b0;
      draw_q    <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (move_valid) begin
            if (legal) begin
              chk_row_q <= move_row;
              chk_col_q <= move_col;
              state_q   <= S_CHECK;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          // Checkers have settled on the plane holding the new stone; a win outranks a full board.
          done_q  <= 1'b1;
          count_q <= count_d;
          if (win_any) begin
            over_q   <= 1'b1;
            winner_q <= turn_q;
            state_q  <= S_OVER;
          end else if (count_d == 8'(CELLS)) begin
            over_q  <= 1'b1;
            draw_q  <= 1'b1;
            state_q <= S_OVER;
          end else begin
            turn_q  <= player_e'(~turn_q);
            state_q <= S_IDLE;
          end
        end
        S_OVER: begin
          if (move_valid) reject_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign move_ready  = (state_q == S_IDLE);
  assign move_reject = reject_q;
  assign move_done   = done_q;
  assign chk_row     = chk_row_q;
  assign chk_col     = chk_col_q;
  assign chk_ch      = (turn_q == WHITE) ? white_ch : black_ch;
  assign turn        = turn_q;
  assign move_count  = count_q;
  assign game_over   = over_q;
  assign winner      = winner_q;
  assign draw        = draw_q;

endmodule

// File: tb/tb_board_move_ctrl.sv
// Scoreboard bench for board_move_ctrl: directed moves push expected outcomes,
// a monitor pops and compares on every move_done / move_reject pulse.
module tb_board_move_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         new_game = 1'b0;
  logic         move_valid = 1'b0;
  logic [3:0]   move_row = '0;
  logic [3:0]   move_col = '0;
  logic         move_ready, move_reject, move_done;
  logic [3:0]   chk_row, chk_col;
  logic [224:0] chk_ch, black_ch, white_ch;
  logic         win_h = 1'b0, win_v = 1'b0, win_d2 = 1'b0;
  logic         win_d1;
  logic         turn, game_over, winner, draw;
  logic [7:0]   move_count;

  bit           use_d1 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit       rej;
    bit [7:0] count;
    bit       turn;
    bit       over;
    bit       winner;
    bit       draw;
  } exp_t;

  exp_t sb_q[$];

  // Bench-side reference model of the game
  bit [224:0] m_black, m_white;
  bit         m_turn, m_over, m_winner, m_draw;
  int         m_count;

  board_move_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_row   (move_row),
    .move_col   (move_col),
    .move_ready (move_ready),
    .move_reject(move_reject),
    .move_done  (move_done),
    .chk_row    (chk_row),
    .chk_col    (chk_col),
    .chk_ch     (chk_ch),
    .win_h      (win_h),
    .win_v      (win_v),
    .win_d1     (win_d1),
    .win_d2     (win_d2),
    .black_ch   (black_ch),
    .white_ch   (white_ch),
    .turn       (turn),
    .move_count (move_count),
    .game_over  (game_over),
    .winner     (winner),
    .draw       (draw)
  );

  always #5 clk = ~clk;

  // Upper-left to lower-right line checker used as the win_d1 source
  function automatic logic diag_win(input logic [224:0] p, input int r, input int c);
    int n = 1;
    int rr = r - 1;
    int cc = c - 1;
    while (rr >= 0 && cc >= 0 && p[rr*15+cc]) begin n++; rr--; cc--; end
    rr = r + 1;
    cc = c + 1;
    while (rr < 15 && cc < 15 && p[rr*15+cc]) begin n++; rr++; cc++; end
    return n >= 5;
  endfunction

  always_comb win_d1 = use_d1 && diag_win(chk_ch, int'(chk_row), int'(chk_col));

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && (move_done || move_reject)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: done=%0b reject=%0b with empty scoreboard", move_done, move_reject);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("reject_pulse", move_reject, e.rej);
        check("done_pulse", move_done, !e.rej);
        check("move_count", move_count, e.count);
        check("turn", turn, e.turn);
        check("game_over", game_over, e.over);
        check("winner", winner, e.winner);
        check("draw", draw, e.draw);
      end
    end
  end

  task automatic model_clear();
    m_black = '0; m_white = '0;
    m_turn = 0; m_over = 0; m_winner = 0; m_draw = 0; m_count = 0;
  endtask

  task automatic start_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
  endtask

  // Issue one move; win is the hand-computed checker result for this move
  task automatic play(input int r, input int c, input bit win, input bit force_h);
    bit   legal;
    int   idx;
    exp_t e;
    @(negedge clk);
    idx   = r * 15 + c;
    legal = !m_over && r < 15 && c < 15 && !(m_black[idx] | m_white[idx]);
    if (legal) begin
      if (m_turn) m_white[idx] = 1'b1;
      else        m_black[idx] = 1'b1;
      m_count++;
      if (win) begin
        m_over = 1; m_winner = m_turn;
      end else if (m_count == 225) begin
        m_over = 1; m_draw = 1;
      end else begin
        m_turn = !m_turn;
      end
    end
    e = '{rej: !legal, count: 8'(m_count), turn: m_turn, over: m_over, winner: m_winner, draw: m_draw};
    sb_q.push_back(e);
    move_valid = 1'b1;
    move_row   = 4'(r);
    move_col   = 4'(c);
    win_h      = force_h;
    @(negedge clk);
    move_valid = 1'b0;
    if (legal) @(negedge clk);
    win_h = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, move_ready, 1'b1);
    check({tag, "_black"}, black_ch, '0);
    check({tag, "_white"}, white_ch, '0);
    check({tag, "_turn"}, turn, 1'b0);
    check({tag, "_count"}, move_count, 8'd0);
    check({tag, "_over"}, game_over, 1'b0);
  endtask

  initial begin
    model_clear();
    #12 rst = 1'b0;
    @(negedge clk);
    check_cleared("reset");
    check("reset_chk_row", chk_row, 4'd0);
    check("reset_chk_col", chk_col, 4'd0);
    check("reset_pulses", {move_done, move_reject, draw, winner}, 4'b0000);

    // First move, then an occupied cell and an out-of-range row
    play(7, 7, 0, 0);
    check("black_112", black_ch[112], 1'b1);
    check("chk_row_77", chk_row, 4'd7);
    check("chk_col_77", chk_col, 4'd7);
    play(7, 7, 0, 0);
    play(15, 3, 0, 0);
    check("black_after_rej", black_ch, m_black);
    check("white_after_rej", white_ch, m_white);

    // Diagonal win for black through the real d1 checker model
    start_new_game();
    use_d1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      play(k, k + 1, 0, 0);
      play(14, k, 0, 0);
    end
    play(4, 5, 1, 0);
    check("d1_over_level", game_over, 1'b1);
    check("d1_not_ready", move_ready, 1'b0);
    play(5, 5, 0, 0);
    check("black_after_over", black_ch, m_black);
    use_d1 = 1'b0;

    // Forced horizontal win on white's move
    start_new_game();
    play(0, 0, 0, 0);
    play(1, 1, 1, 1);
    check("white_win_plane", white_ch[16], 1'b1);

    // Full board with no winner
    start_new_game();
    for (int i = 0; i < 225; i++) play(i / 15, i % 15, 0, 0);
    check("full_black", black_ch, m_black);
    check("full_white", white_ch, m_white);
    check("full_draw", {game_over, draw}, 2'b11);

    // new_game while CHECK is in progress discards the pending result
    start_new_game();
    @(negedge clk);
    move_valid = 1'b1; move_row = 4'd3; move_col = 4'd3;
    @(negedge clk);
    move_valid = 1'b0; new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    check("ng_done_low", move_done, 1'b0);
    check_cleared("ng_check");
    model_clear();

    // Asynchronous reset in the middle of CHECK
    @(negedge clk);
    move_valid = 1'b1; move_row = 4'd2; move_col = 4'd9;
    @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    move_valid = 1'b0;
    check_cleared("async_rst");
    repeat (3) @(negedge clk);
    check("async_no_done", move_done, 1'b0);
    check("async_still_idle", move_ready, 1'b1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/board_move_ctrl.md
Name: board_move_ctrl

Overview:
- Sequential move/board controller sitting directly upstream of the four five-in-a-row line checkers: horizontal, vertical, upper-left→lower-right diagonal, upper-right→lower-left diagonal.
- Owns the 15x15 board as two 225-bit occupancy planes (black, white) and accepts moves from the player-input or AI source.
- Rejects illegal moves and drives the checkers with the last move's row/col and the mover's plane.
- Samples the checkers' win_check outputs, then alternates turns or declares win/draw.

Parameters:
- BOARD_N, 15, board side length; cell index = row*BOARD_N + col.
- CELLS, 225, BOARD_N*BOARD_N; width of each plane and range of the move counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- new_game  in  1  synchronous clear of board and game state; accepted in any state.
- move_valid  in  1  move request strobe.
- move_row  in  4  requested row, legal range 0..14.
- move_col  in  4  requested column, legal range 0..14.
- move_ready  out  1  high only in IDLE; a move is accepted when move_valid && move_ready.
- move_reject  out  1  one-cycle pulse: the request was illegal.
- move_done  out  1  one-cycle pulse: an accepted move has finished checking.
- chk_row  out  4  row of the last accepted move; drives the checkers' row.
- chk_col  out  4  column of the last accepted move; drives the checkers' col.
- chk_ch  out  225  plane of the player who made the last move; drives the checkers' ch.
- win_h, win_v, win_d1, win_d2  in  1 each  combinational win_check results from the four checkers.
- black_ch  out  225  black occupancy plane (to display/AI).
- white_ch  out  225  white occupancy plane (to display/AI).
- turn  out  1  side to move: 0 = black, 1 = white.
- move_count  out  8  stones placed, 0..225.
- game_over  out  1  level, high in OVER.
- winner  out  1  winning side; valid only when game_over && !draw.
- draw  out  1  board full with no win.

Behaviour:
- Reset (async, rst=1):
  - all planes 0, chk_row/chk_col 0, turn 0 (black first), move_count 0;
  - all pulses and flags 0; state IDLE, so move_ready=1 after reset release.
- new_game at a clock edge: identical effect to reset, synchronously. It has priority over any move in the same cycle, including mid-CHECK; the pending result is discarded and no move_done is issued.
- States: IDLE, CHECK, OVER.
- IDLE, with move_valid sampled high:
  - Illegal if move_row>14, move_col>14, or (black_ch|white_ch)[row*15+col]==1.
  - Illegal: move_reject=1 for the next cycle; no state, board or turn change.
  - Legal: set bit row*15+col in the plane selected by turn, latch chk_row/chk_col, go to CHECK.
  - Index arithmetic is done at 8 bits; the range check precedes indexing, so an out-of-range request never writes.
- CHECK (exactly one cycle):
  - chk_ch = plane of turn, already including the new stone; the checkers settle combinationally.
  - At the edge ending CHECK: move_count += 1 and move_done=1 for one cycle.
  - If any of win_h/win_v/win_d1/win_d2 is 1: game_over=1, winner=turn, go to OVER; turn is not toggled.
  - Else if the incremented count == 225: game_over=1, draw=1, go to OVER.
  - Else: toggle turn, go to IDLE.
- Latency: request accepted at edge T0; move_done and the result are visible after edge T1; next move accepted no earlier than T2.
- OVER: move_ready=0. Any move_valid produces move_reject and no change. Stays in OVER until new_game or rst.
- move_valid is ignored (not rejected) while in CHECK.
- Between moves, chk_* hold their last values. In IDLE, chk_ch follows the plane of turn; the checkers' outputs are ignored outside CHECK.
- A win and a full board on the same move count as a win: draw=0.

Decomposition:
- Package gobang_pkg:
  - BOARD_N, CELLS, IDX_W=8;
  - player encoding BLACK=0, WHITE=1;
  - state enum {IDLE, CHECK, OVER};
  - helper function cell_idx(row, col) = row*BOARD_N + col.
- Sub-module board_plane: one 225-bit register with async reset, synchronous clear, and single-bit set at an index plus a write enable. Instantiated twice (black, white).

Test Plan:
- Reset then black (7,7): accepted; black_ch[112]=1; move_done one cycle after acceptance; turn=1; move_count=1.
- Replay (7,7) as white, then (15,3): two move_reject pulses; board, turn and count unchanged.
- Black plays idx 1,17,33,49,65 ((0,1),(1,2),(2,3),(3,4),(4,5)), interleaved with white at (14,0..3), with the real upper_left_to_lower_right model on win_d1:
  - 5th black move gives game_over=1, winner=0, draw=0, move_count=9;
  - a further move_valid is rejected.
- Force win_h=1 during white's CHECK: game_over=1, winner=1.
- Fill all 225 cells with all win inputs tied 0: after the 225th move done, draw=1, game_over=1.
- Assert new_game during CHECK, and rst asynchronously mid-cycle: planes 0, turn 0, state IDLE, no move_done emitted.
